fpu_sched: RTL

FPU_SCHED -- requirements
Module: fpu_sched

---
 rtl/fpu_sched.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/fpu_sched.sv
// fpu_sched: two-requester round-robin front end for one shared, pipelined
// bfloat16 FPU. Each requester may have one operation in flight. The chosen
// operation is registered onto the FPU port. A valid/id/err tag follows it
// through an FPU_LAT-deep shift pipeline, and the FPU result is captured into
// the owning requester's result register when the tag leaves that pipeline.
//
// Ports
//   clk, rst                      clock and synchronous active-high reset
//   reqN_valid_i / reqN_ready_o   request handshake (ready is the combinational grant)
//   reqN_mode_i                   one-hot opcode: 0001 add, 0010 sub, 0100 mul, 1000 div
//   reqN_a_i, reqN_b_i            bfloat16 operands
//   rspN_valid_o / rspN_ready_i   response handshake
//   rspN_data_o, rspN_ovf_o       result and overflow flag
//   rspN_err_o                    mode was not one-hot; data and ovf are forced to 0
//   fpu_mode_o, fpu_in1_o/in2_o   registered drive to the shared FPU
//   fpu_out_i, fpu_ovf_i          FPU result, valid FPU_LAT cycles after issue
module fpu_sched #(
  parameter int FPU_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid_i,
  output logic        req0_ready_o,
  input  logic [3:0]  req0_mode_i,
  input  logic [15:0] req0_a_i,
  input  logic [15:0] req0_b_i,
  input  logic        req1_valid_i,
  output logic        req1_ready_o,
  input  logic [3:0]  req1_mode_i,
  input  logic [15:0] req1_a_i,
  input  logic [15:0] req1_b_i,
  output logic        rsp0_valid_o,
  input  logic        rsp0_ready_i,
  output logic [15:0] rsp0_data_o,
  output logic        rsp0_ovf_o,
  output logic        rsp0_err_o,
  output logic        rsp1_valid_o,
  input  logic        rsp1_ready_i,
  output logic [15:0] rsp1_data_o,
  output logic        rsp1_ovf_o,
  output logic        rsp1_err_o,
  output logic [3:0]  fpu_mode_o,
  output logic [15:0] fpu_in1_o,
  output logic [15:0] fpu_in2_o,
  input  logic [15:0] fpu_out_i,
  input  logic        fpu_ovf_i
);

  logic [1:0]  w_req_valid;
  logic [1:0]  w_rsp_ready;
  logic [1:0]  w_busy;
  logic [1:0]  w_elig;
  logic [1:0]  w_gnt;
  logic        w_gnt_any;
  logic        w_gnt_id;
  logic [3:0]  w_sel_mode;
  logic [15:0] w_sel_a;
  logic [15:0] w_sel_b;
  logic        w_mode_ok;
  logic [1:0]  w_rsp_valid;
  logic [1:0]  w_rsp_ovf;
  logic [1:0]  w_rsp_err;
  logic [15:0] w_rsp_data [2];
  logic        w_cap_v;
  logic        w_cap_id;
  logic        w_cap_err;

  logic               r_ptr;
  logic [FPU_LAT-1:0] r_tag_v;
  logic [FPU_LAT-1:0] r_tag_id;
  logic [FPU_LAT-1:0] r_tag_err;
  logic [3:0]         r_fpu_mode;
  logic [15:0]        r_fpu_in1;
  logic [15:0]        r_fpu_in2;

  assign w_req_valid = {req1_valid_i, req0_valid_i};
  assign w_rsp_ready = {rsp1_ready_i, rsp0_ready_i};

  // Round-robin: on contention the pointer decides. Reset blocks every grant.
  always_comb begin
    w_gnt = 2'b00;
    if (!rst) begin
      if (w_elig == 2'b11) w_gnt = r_ptr ? 2'b10 : 2'b01;
      else                 w_gnt = w_elig;
    end
  end

  assign w_gnt_any  = |w_gnt;
  assign w_gnt_id   = w_gnt[1];
  assign w_sel_mode = w_gnt_id ? req1_mode_i : req0_mode_i;
  assign w_sel_a    = w_gnt_id ? req1_a_i : req0_a_i;
  assign w_sel_b    = w_gnt_id ? req1_b_i : req0_b_i;
  // A mode is one-hot when it is nonzero and clearing its lowest set bit leaves zero.
  assign w_mode_ok  = (w_sel_mode != 4'd0) && ((w_sel_mode & (w_sel_mode - 4'd1)) == 4'd0);

  assign req0_ready_o = w_gnt[0];
  assign req1_ready_o = w_gnt[1];

  // The operands hold while idle, so the FPU inputs do not toggle without an issue.
  // Only the mode drops to 0000.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr      <= 1'b0;
      r_fpu_mode <= 4'd0;
      r_fpu_in1  <= 16'd0;
      r_fpu_in2  <= 16'd0;
    end else if (w_gnt_any) begin
      r_ptr      <= ~w_gnt_id;
      r_fpu_mode <= w_mode_ok ? w_sel_mode : 4'd0;
      r_fpu_in1  <= w_sel_a;
      r_fpu_in2  <= w_sel_b;
    end else begin
      r_fpu_mode <= 4'd0;
    end
  end

  assign fpu_mode_o = r_fpu_mode;
  assign fpu_in1_o  = r_fpu_in1;
  assign fpu_in2_o  = r_fpu_in2;

  // Tag shift pipeline. Stage k holds the op issued k+1 edges ago, so the last
  // stage marks the edge at which fpu_out_i belongs to that op.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tag_v   <= '0;
      r_tag_id  <= '0;
      r_tag_err <= '0;
    end else begin
      r_tag_v[0]   <= w_gnt_any;
      r_tag_id[0]  <= w_gnt_id;
      r_tag_err[0] <= ~w_mode_ok;
      for (int k = 1; k < FPU_LAT; k++) begin
        r_tag_v[k]   <= r_tag_v[k-1];
        r_tag_id[k]  <= r_tag_id[k-1];
        r_tag_err[k] <= r_tag_err[k-1];
      end
    end
  end

  assign w_cap_v   = r_tag_v[FPU_LAT-1];
  assign w_cap_id  = r_tag_id[FPU_LAT-1];
  assign w_cap_err = r_tag_err[FPU_LAT-1];

  // Per-requester busy flag and result register. Busy stays set until the
  // response handshake. That rules out a capture and a handshake on the same
  // requester in one cycle, and it rules out overwriting an unread result.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_req
      logic        r_busy;
      logic        r_rsp_valid;
      logic [15:0] r_rsp_data;
      logic        r_rsp_ovf;
      logic        r_rsp_err;
      logic        w_cap;
      logic        w_hs;

      assign w_cap = w_cap_v && (w_cap_id == 1'(gi));
      assign w_hs  = r_rsp_valid && w_rsp_ready[gi];

      always_ff @(posedge clk) begin
        if (rst) begin
          r_busy      <= 1'b0;
          r_rsp_valid <= 1'b0;
          r_rsp_data  <= 16'd0;
          r_rsp_ovf   <= 1'b0;
          r_rsp_err   <= 1'b0;
        end else begin
          if (w_gnt[gi])  r_busy <= 1'b1;
          else if (w_hs)  r_busy <= 1'b0;

          if (w_cap) begin
            r_rsp_valid <= 1'b1;
            r_rsp_data  <= w_cap_err ? 16'd0 : fpu_out_i;
            r_rsp_ovf   <= w_cap_err ? 1'b0 : fpu_ovf_i;
            r_rsp_err   <= w_cap_err;
          end else if (w_hs) begin
            r_rsp_valid <= 1'b0;
          end
        end
      end

      assign w_busy[gi]      = r_busy;
      assign w_elig[gi]      = w_req_valid[gi] & ~r_busy;
      assign w_rsp_valid[gi] = r_rsp_valid;
      assign w_rsp_data[gi]  = r_rsp_data;
      assign w_rsp_ovf[gi]   = r_rsp_ovf;
      assign w_rsp_err[gi]   = r_rsp_err;
    end
  endgenerate

  assign rsp0_valid_o = w_rsp_valid[0];
  assign rsp0_data_o  = w_rsp_data[0];
  assign rsp0_ovf_o   = w_rsp_ovf[0];
  assign rsp0_err_o   = w_rsp_err[0];
  assign rsp1_valid_o = w_rsp_valid[1];
  assign rsp1_data_o  = w_rsp_data[1];
  assign rsp1_ovf_o   = w_rsp_ovf[1];
  assign rsp1_err_o   = w_rsp_err[1];

endmodule
